// File: rtl/reg_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | reg_fifo : register-based FIFO with full/empty flags, count and flush.    |
// | Revision : 1.0                                                            |
// +--------------------------------------------------------------------------+
module reg_fifo #(
  parameter int width = 1,
  parameter int depth = 2,
  localparam int cw = $clog2(depth + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enq_en,
  input  logic [width-1:0] enq_data,
  output logic             not_full,
  input  logic             deq_en,
  output logic [width-1:0] deq_data,
  output logic             not_empty,
  output logic [cw-1:0]    count,
  input  logic             clr
);

  localparam int pw = (depth > 1) ? $clog2(depth) : 1;

  logic [width-1:0] mem_q [depth];
  logic [pw-1:0]    head_q, head_d;
  logic [pw-1:0]    tail_q, tail_d;
  logic [cw-1:0]    count_q, count_d;
  logic             not_empty_q, not_empty_d;
  logic             not_full_q, not_full_d;
  logic             deq_acc;
  logic             enq_acc;

  always_comb begin
    deq_acc = deq_en & not_empty_q;
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    enq_acc = enq_en & (not_full_q | deq_acc);
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (clr) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (enq_acc) tail_d = (tail_q == pw'(depth - 1)) ? '0 : tail_q + pw'(1);
      if (deq_acc) head_d = (head_q == pw'(depth - 1)) ? '0 : head_q + pw'(1);
      if (enq_acc && !deq_acc)      count_d = count_q + cw'(1);
      else if (deq_acc && !enq_acc) count_d = count_q - cw'(1);
    end
    not_empty_d = (count_d != '0);
    not_full_d  = (count_d != cw'(depth));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      not_empty_q <= 1'b0;
      not_full_q  <= 1'b1;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      not_empty_q <= not_empty_d;
      not_full_q  <= not_full_d;
    end
  end

  // Storage is deliberately left out of reset; validity comes from count.
  always_ff @(posedge clk) begin
    if (enq_acc && !clr) mem_q[tail_q] <= enq_data;
  end

  assign deq_data  = not_empty_q ? mem_q[head_q] : '0;
  assign not_empty = not_empty_q;
  assign not_full  = not_full_q;
  assign count     = count_q;

endmodule
`default_nettype wire

// File: tb/tb_reg_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_reg_fifo : directed self-checking bench for reg_fifo (depth 4 and 3).  |
// | Revision    : 1.0                                                         |
// +--------------------------------------------------------------------------+
module tb_reg_fifo;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clr;
  logic       enq_en, deq_en;
  logic [7:0] enq_data;
  logic [7:0] deq_data;
  logic       not_full, not_empty;
  logic [2:0] count;
  logic       enq_en3, deq_en3;
  logic [7:0] enq_data3;
  logic [7:0] deq_data3;
  logic       not_full3, not_empty3;
  logic [1:0] count3;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  reg_fifo #(.width(8), .depth(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .enq_en(enq_en), .enq_data(enq_data),
    .not_full(not_full), .deq_en(deq_en), .deq_data(deq_data),
    .not_empty(not_empty), .count(count), .clr(clr)
  );

  reg_fifo #(.width(8), .depth(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .enq_en(enq_en3), .enq_data(enq_data3),
    .not_full(not_full3), .deq_en(deq_en3), .deq_data(deq_data3),
    .not_empty(not_empty3), .count(count3), .clr(clr)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    enq_en = 1'b1; enq_data = d;
    cyc();
    enq_en = 1'b0;
  endtask

  task automatic pop();
    deq_en = 1'b1;
    cyc();
    deq_en = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (not_empty !== 1'b0) begin failures++; $display("FAIL reset_not_empty got=%b exp=0", not_empty); end
    checks++; if (not_full !== 1'b1) begin failures++; $display("FAIL reset_not_full got=%b exp=1", not_full); end
    checks++; if (deq_data !== 8'h00) begin failures++; $display("FAIL reset_deq_data got=%h exp=00", deq_data); end
    #10 rst_n = 1'b1;
    cyc();
    push(8'hAB);
    push(8'hCD);
    checks++; if (count !== 3'd2) begin failures++; $display("FAIL pre_reset_count got=%0d exp=2", count); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL midcycle_reset_count got=%0d exp=0", count); end
    checks++; if (not_empty !== 1'b0 || not_full !== 1'b1) begin failures++; $display("FAIL midcycle_reset_flags got=%b%b exp=01", not_empty, not_full); end
    checks++; if (deq_data !== 8'h00) begin failures++; $display("FAIL midcycle_reset_deq_data got=%h exp=00", deq_data); end
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_fill_drain();
    logic [7:0] vals [4];
    vals = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) begin
      push(vals[i]);
      checks++; if (count !== 3'(i + 1)) begin failures++; $display("FAIL fill_count[%0d] got=%0d exp=%0d", i, count, i + 1); end
    end
    checks++; if (not_full !== 1'b0) begin failures++; $display("FAIL fill_not_full got=%b exp=0", not_full); end
    push(8'h55);
    checks++; if (count !== 3'd4) begin failures++; $display("FAIL overflow_count got=%0d exp=4", count); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (deq_data !== vals[i]) begin failures++; $display("FAIL drain_data[%0d] got=%h exp=%h", i, deq_data, vals[i]); end
      pop();
    end
    checks++; if (not_empty !== 1'b0) begin failures++; $display("FAIL drain_not_empty got=%b exp=0", not_empty); end
    checks++; if (deq_data !== 8'h00) begin failures++; $display("FAIL drain_deq_data got=%h exp=00", deq_data); end
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL drain_count got=%0d exp=0", count); end
  endtask

  task automatic test_full_enq_deq();
    logic [7:0] exp [4];
    exp = '{8'h22, 8'h33, 8'h44, 8'hAA};
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    checks++; if (deq_data !== 8'h11) begin failures++; $display("FAIL full_head got=%h exp=11", deq_data); end
    enq_en = 1'b1; enq_data = 8'hAA; deq_en = 1'b1;
    cyc();
    enq_en = 1'b0; deq_en = 1'b0;
    checks++; if (count !== 3'd4) begin failures++; $display("FAIL full_pass_count got=%0d exp=4", count); end
    checks++; if (not_full !== 1'b0) begin failures++; $display("FAIL full_pass_not_full got=%b exp=0", not_full); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (deq_data !== exp[i]) begin failures++; $display("FAIL full_pass_drain[%0d] got=%h exp=%h", i, deq_data, exp[i]); end
      pop();
    end
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL full_pass_end_count got=%0d exp=0", count); end
  endtask

  task automatic test_empty_enq_deq();
    enq_en = 1'b1; enq_data = 8'h5A; deq_en = 1'b1;
    cyc();
    enq_en = 1'b0; deq_en = 1'b0;
    checks++; if (count !== 3'd1) begin failures++; $display("FAIL empty_enqdeq_count got=%0d exp=1", count); end
    checks++; if (deq_data !== 8'h5A) begin failures++; $display("FAIL empty_enqdeq_data got=%h exp=5a", deq_data); end
    checks++; if (not_empty !== 1'b1) begin failures++; $display("FAIL empty_enqdeq_not_empty got=%b exp=1", not_empty); end
    pop();
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL empty_enqdeq_drain got=%0d exp=0", count); end
  endtask

  // Values 1..10 pass through the depth-3 FIFO with two entries in flight.
  task automatic test_wrap_depth3();
    logic [1:0] exp_cnt;
    for (int k = 1; k <= 12; k++) begin
      enq_en3   = (k <= 10);
      enq_data3 = 8'(k);
      deq_en3   = (k >= 3);
      if (k >= 3) begin
        checks++; if (deq_data3 !== 8'(k - 2)) begin failures++; $display("FAIL wrap_data[%0d] got=%0d exp=%0d", k, deq_data3, k - 2); end
      end
      cyc();
      exp_cnt = (k == 1) ? 2'd1 : (k <= 10) ? 2'd2 : (k == 11) ? 2'd1 : 2'd0;
      checks++; if (count3 !== exp_cnt) begin failures++; $display("FAIL wrap_count[%0d] got=%0d exp=%0d", k, count3, exp_cnt); end
      checks++; if (not_full3 !== 1'b1) begin failures++; $display("FAIL wrap_not_full[%0d] got=%b exp=1", k, not_full3); end
    end
    enq_en3 = 1'b0; deq_en3 = 1'b0;
    checks++; if (not_empty3 !== 1'b0) begin failures++; $display("FAIL wrap_end_not_empty got=%b exp=0", not_empty3); end
  endtask

  task automatic test_flush_and_reset();
    push(8'h01); push(8'h02); push(8'h03);
    checks++; if (count !== 3'd3) begin failures++; $display("FAIL flush_pre_count got=%0d exp=3", count); end
    clr = 1'b1; enq_en = 1'b1; enq_data = 8'h99; deq_en = 1'b1;
    cyc();
    clr = 1'b0; enq_en = 1'b0; deq_en = 1'b0;
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL flush_count got=%0d exp=0", count); end
    checks++; if (not_empty !== 1'b0 || deq_data !== 8'h00) begin failures++; $display("FAIL flush_empty got=%b/%h exp=0/00", not_empty, deq_data); end
    push(8'h77);
    checks++; if (deq_data !== 8'h77 || count !== 3'd1) begin failures++; $display("FAIL flush_after got=%h/%0d exp=77/1", deq_data, count); end
    push(8'h78);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL async_reset_count got=%0d exp=0", count); end
    checks++; if (not_empty !== 1'b0) begin failures++; $display("FAIL async_reset_not_empty got=%b exp=0", not_empty); end
    rst_n = 1'b1;
    cyc();
    push(8'h12);
    checks++; if (deq_data !== 8'h12 || count !== 3'd1) begin failures++; $display("FAIL post_reset got=%h/%0d exp=12/1", deq_data, count); end
    pop();
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL post_reset_drain got=%0d exp=0", count); end
  endtask

  initial begin
    clr = 1'b0; enq_en = 1'b0; deq_en = 1'b0; enq_data = '0;
    enq_en3 = 1'b0; deq_en3 = 1'b0; enq_data3 = '0;
    test_reset();
    test_fill_drain();
    test_full_enq_deq();
    test_empty_enq_deq();
    test_wrap_depth3();
    test_flush_and_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
